ped_crossing_ctrl: RTL

//   Sequencer for the button-actioned pedestrian crossing. Latches pedestrian button requests,

---
 rtl/ped_crossing_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ped_crossing_ctrl.sv
// Button-actioned pedestrian crossing sequencer; lamp outputs are decoded from registered state only.
// Optional pedestrian countdown output is enabled by defining PED_COUNTDOWN_EN.
module ped_crossing_ctrl #(
  parameter int CAR_GREEN_MIN = 30,
  parameter int CAR_YELLOW    = 3,
  parameter int ALL_RED       = 2,
  parameter int PED_GREEN     = 10,
  parameter int PED_BLINK     = 5,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  output logic             car_red,
  output logic             car_yellow,
  output logic             car_green,
  output logic             ped_red,
  output logic             ped_green,
  output logic             wait_lamp
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [CNT_W-1:0] ped_cnt
`endif
);

  typedef enum logic [2:0] {
    S_CAR_GREEN  = 3'd0,
    S_CAR_YELLOW = 3'd1,
    S_ALL_RED1   = 3'd2,
    S_PED_GREEN  = 3'd3,
    S_PED_BLINK  = 3'd4,
    S_ALL_RED2   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(CAR_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(CAR_YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PED_GREEN - 1);
  localparam logic [CNT_W-1:0] PB_LAST   = CNT_W'(PED_BLINK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             req_q, req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CAR_GREEN;
      tmr_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q + CNT_W'(1);
    req_d      = req_q;
    car_red    = 1'b1;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_red    = 1'b1;
    ped_green  = 1'b0;
    case (state_q)
      S_CAR_GREEN: begin
        car_red   = 1'b0;
        car_green = 1'b1;
        if (btn) req_d = 1'b1;
        if (tmr_q == GMIN_LAST) begin
          tmr_d = tmr_q;
          if (req_q || btn) state_d = S_CAR_YELLOW;
        end
      end
      S_CAR_YELLOW: begin
        car_red    = 1'b0;
        car_yellow = 1'b1;
        if (btn) req_d = 1'b1;
        if (tmr_q == YEL_LAST) state_d = S_ALL_RED1;
      end
      S_ALL_RED1: begin
        if (btn) req_d = 1'b1;
        // Serving the request on entry to pedestrian green overrides a same-edge press.
        if (tmr_q == RED_LAST) begin
          state_d = S_PED_GREEN;
          req_d   = 1'b0;
        end
      end
      S_PED_GREEN: begin
        ped_red   = 1'b0;
        ped_green = 1'b1;
        if (tmr_q == PG_LAST) state_d = S_PED_BLINK;
      end
      S_PED_BLINK: begin
        ped_red   = 1'b0;
        ped_green = ~tmr_q[0];
        if (tmr_q == PB_LAST) state_d = S_ALL_RED2;
      end
      S_ALL_RED2: begin
        if (tmr_q == RED_LAST) state_d = S_CAR_GREEN;
      end
      default: begin
        state_d = S_CAR_GREEN;
      end
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  assign wait_lamp = req_q;

`ifdef PED_COUNTDOWN_EN
  always_comb begin
    ped_cnt = '0;
    if (state_q == S_PED_GREEN)
      ped_cnt = CNT_W'(PED_GREEN + PED_BLINK) - tmr_q;
    else if (state_q == S_PED_BLINK)
      ped_cnt = CNT_W'(PED_BLINK) - tmr_q;
  end
`endif

endmodule
